// File: rtl/usys_array_tile_pkg.sv
// Shared types, constants and helpers for the unary systolic GEMM tile.
`ifndef USYS_ARRAY_TILE_PKG_SV
`define USYS_ARRAY_TILE_PKG_SV

// True when an accumulator of width ow cannot overflow for h rows of iw-bit operands.
`define USYS_OWIDTH_OK(ow, iw, h) ((ow) >= 2 * (iw) - 1 + $clog2(h))

package usys_pkg;

    // Legacy state encodings, kept so older code can keep matching on raw values.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MAC   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        MAC   = ST_MAC,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } state_t;

    typedef enum logic {
        TEMPORAL = 1'b0,
        RATE     = 1'b1
    } coding_t;

    // Feedback taps for the 7-bit LFSR used with 8-bit operands (x^7 + x^6 + 1).
    localparam logic [6:0] LFSR7_TAPS = 7'b110_0000;

    // Maximal-length Fibonacci tap masks; bit i set means stage i+1 feeds back.
    function automatic logic [15:0] lfsr_taps(input int unsigned width);
        case (width)
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'(LFSR7_TAPS);
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            default: return 16'hD008;
        endcase
    endfunction

    // Per-row LFSR seed; never zero so no row can lock up.
    function automatic int unsigned seed(input int unsigned h);
        return h + 1;
    endfunction

endpackage

`endif

// File: rtl/usys_array_tile_if.sv
// Host-side bus of the tile: weight load, run control, input vector and results.
interface usys_array_tile_if #(
    parameter int unsigned HEIGHT = 32,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned IWIDTH = 8,
    parameter int unsigned OWIDTH = 24
) ();

    logic                             w_valid;
    logic [WIDTH-1:0][IWIDTH-1:0]     wght;
    logic                             start;
    logic                             mode;
    logic [IWIDTH-1:0]                mac_cyc;
    logic [HEIGHT-1:0][IWIDTH-1:0]    ifm;
    logic                             busy;
    logic                             ofm_valid;
    logic [WIDTH-1:0][OWIDTH-1:0]     ofm;

    modport master (
        output w_valid, wght, start, mode, mac_cyc, ifm,
        input  busy, ofm_valid, ofm
    );

    modport slave (
        input  w_valid, wght, start, mode, mac_cyc, ifm,
        output busy, ofm_valid, ofm
    );

endinterface

// File: rtl/usys_array_tile_pe.sv
// One processing element: stationary weight, unary bit forwarding, partial-sum add.
module usys_pe
    import usys_pkg::*;
#(
    parameter int unsigned IWIDTH = 8,
    parameter int unsigned OWIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic signed [IWIDTH-1:0] w_src,
    output logic signed [IWIDTH-1:0] wght,
    input  logic                     ubit,
    input  logic                     usign,
    input  logic                     uvalid,
    output logic                     fbit,
    output logic                     fsign,
    output logic                     fvalid,
    input  logic signed [OWIDTH-1:0] psum_below,
    output logic signed [OWIDTH-1:0] psum
);

    logic signed [OWIDTH-1:0] wext;
    logic signed [OWIDTH-1:0] contrib;

    // Widen before negating so a weight of the most negative value negates cleanly.
    assign wext = {{(OWIDTH - IWIDTH){wght[IWIDTH-1]}}, wght};

    // Signed contribution of this cycle's unary bit; sign(ifm) xor sign(W) folds into negating W.
    always_comb begin
        contrib = '0;
        if (uvalid && ubit) begin
            contrib = usign ? -wext : wext;
        end
    end

    // Weight shift on load, forward the bit stream right, register the partial sum upward.
    always_ff @(posedge clk) begin
        if (rst) begin
            wght   <= '0;
            fbit   <= 1'b0;
            fsign  <= 1'b0;
            fvalid <= 1'b0;
            psum   <= '0;
        end else begin
            if (load) begin
                wght <= w_src;
            end
            fbit   <= ubit;
            fsign  <= usign;
            fvalid <= uvalid;
            psum   <= psum_below + contrib;
        end
    end

endmodule

// File: rtl/usys_array_tile.sv
// Weight-stationary unary systolic GEMM tile: run sequencer, unary generators, PE grid, accumulators.
module usys_array_tile
    import usys_pkg::*;
#(
    parameter int unsigned HEIGHT = 32,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned IWIDTH = 8,
    parameter int unsigned OWIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    usys_array_tile_if.slave bus
);

    localparam int unsigned LW        = IWIDTH - 1;
    localparam int unsigned NMAX      = 2 ** (IWIDTH - 1);
    localparam int unsigned DRAIN_LEN = HEIGHT + WIDTH + 1;
    localparam int unsigned DW        = $clog2(DRAIN_LEN + 1);

    localparam logic [IWIDTH-1:0] NMAX_V     = IWIDTH'(NMAX);
    localparam logic [DW-1:0]     DRAIN_LAST = DW'(DRAIN_LEN - 1);
    localparam logic [LW-1:0]     TAPS       = LW'(lfsr_taps(LW));

    if (!`USYS_OWIDTH_OK(OWIDTH, IWIDTH, HEIGHT)) begin : g_owidth_check
        $error("usys_array_tile: OWIDTH too narrow for IWIDTH/HEIGHT");
    end

    state_t            state;
    coding_t           mode_r;
    logic [IWIDTH-1:0] k;
    logic [IWIDTH-1:0] n_last;
    logic [IWIDTH-1:0] win_sel;
    logic [DW-1:0]     dcnt;
    logic              start_ok;
    logic              load_ok;

    logic [WIDTH-1:0][OWIDTH-1:0] ofm_r;
    logic signed [OWIDTH-1:0]     acc  [WIDTH];
    logic [2:0]                   fwd  [HEIGHT][WIDTH+1];   // {valid, sign, bit}
    logic signed [OWIDTH-1:0]     psum [HEIGHT+1][WIDTH];
    logic signed [IWIDTH-1:0]     wreg [HEIGHT][WIDTH];

    // start has priority over w_valid; both only count while idle.
    assign start_ok = (state == IDLE) && bus.start;
    assign load_ok  = (state == IDLE) && bus.w_valid && !bus.start;

    assign bus.busy      = (state != IDLE);
    assign bus.ofm_valid = (state == DONE);
    assign bus.ofm       = ofm_r;

    // Window length: zero or anything above NMAX runs the full window.
    always_comb begin
        win_sel = bus.mac_cyc;
        if (bus.mac_cyc == '0 || bus.mac_cyc > NMAX_V) begin
            win_sel = NMAX_V;
        end
    end

    // Run sequencer: IDLE -> MAC (N cycles) -> DRAIN (pipeline flush) -> DONE -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mode_r <= TEMPORAL;
            k      <= '0;
            n_last <= '0;
            dcnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= MAC;
                        mode_r <= coding_t'(bus.mode);
                        k      <= '0;
                        n_last <= win_sel - IWIDTH'(1);
                    end
                end
                MAC: begin
                    k <= k + IWIDTH'(1);
                    if (k == n_last) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end
                end
                DRAIN: begin
                    dcnt <= dcnt + DW'(1);
                    if (dcnt == DRAIN_LAST) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar h = 0; h < HEIGHT; h++) begin : g_row
        localparam int unsigned D = HEIGHT - 1 - h;

        logic              sgn;
        logic [LW-1:0]     mag;
        logic [LW-1:0]     lfsr;
        logic [IWIDTH-1:0] x_abs;
        logic              uvalid;
        logic              ubit;
        logic [2:0]        sk [D+1];

        assign x_abs  = bus.ifm[h][IWIDTH-1] ? -bus.ifm[h] : bus.ifm[h];
        assign uvalid = (state == MAC);
        assign ubit   = uvalid && ((mode_r == RATE) ? (mag != '0 && lfsr <= mag)
                                                    : (k < {1'b0, mag}));

        // Capture sign/saturated magnitude at start; step the row LFSR once per MAC cycle.
        always_ff @(posedge clk) begin
            if (rst) begin
                sgn  <= 1'b0;
                mag  <= '0;
                lfsr <= LW'(seed(h));
            end else if (start_ok) begin
                sgn  <= bus.ifm[h][IWIDTH-1];
                mag  <= x_abs[IWIDTH-1] ? '1 : x_abs[LW-1:0];
                lfsr <= LW'(seed(h));
            end else if (state == MAC) begin
                lfsr <= {lfsr[LW-2:0], ^(lfsr & TAPS)};
            end
        end

        // Register the generated bit, then delay row h by HEIGHT-1-h cycles to skew the wavefront.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned i = 0; i <= D; i++) begin
                    sk[i] <= '0;
                end
            end else begin
                sk[0] <= {uvalid, sgn, ubit};
                for (int unsigned i = 1; i <= D; i++) begin
                    sk[i] <= sk[i-1];
                end
            end
        end

        assign fwd[h][0] = sk[D];

        for (genvar w = 0; w < WIDTH; w++) begin : g_col
            logic signed [IWIDTH-1:0] w_src;

            if (h == 0) begin : g_top
                assign w_src = bus.wght[w];
            end else begin : g_below
                assign w_src = wreg[h-1][w];
            end

            usys_pe #(
                .IWIDTH(IWIDTH),
                .OWIDTH(OWIDTH)
            ) u_pe (
                .clk        (clk),
                .rst        (rst),
                .load       (load_ok),
                .w_src      (w_src),
                .wght       (wreg[h][w]),
                .ubit       (fwd[h][w][0]),
                .usign      (fwd[h][w][1]),
                .uvalid     (fwd[h][w][2]),
                .fbit       (fwd[h][w+1][0]),
                .fsign      (fwd[h][w+1][1]),
                .fvalid     (fwd[h][w+1][2]),
                .psum_below (psum[h+1][w]),
                .psum       (psum[h][w])
            );
        end
    end

    for (genvar w = 0; w < WIDTH; w++) begin : g_psum_floor
        assign psum[HEIGHT][w] = '0;
    end

    // Column tops: the row-0 forwarded valid marks cycles whose partial sum is a real column sum.
    always_ff @(posedge clk) begin
        for (int unsigned w = 0; w < WIDTH; w++) begin
            if (rst || start_ok) begin
                acc[w] <= '0;
            end else if (fwd[0][w+1][2]) begin
                acc[w] <= acc[w] + psum[0][w];
            end
        end
    end

    // Publish results on the last drain cycle so they appear together with ofm_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            ofm_r <= '0;
        end else if (state == DRAIN && dcnt == DRAIN_LAST) begin
            for (int unsigned w = 0; w < WIDTH; w++) begin
                ofm_r[w] <= acc[w];
            end
        end
    end

endmodule

// File: tb/tb_usys_array_tile.sv
// Directed bench for usys_array_tile in a 4x4 configuration with hand-computed results.
module tb_usys_array_tile;

    typedef logic signed [7:0] mat_t [4][4];
    typedef int vec_t [4];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    usys_array_tile_if #(.HEIGHT(4), .WIDTH(4), .IWIDTH(8), .OWIDTH(24)) bus ();

    usys_array_tile #(
        .HEIGHT(4),
        .WIDTH (4),
        .IWIDTH(8),
        .OWIDTH(24)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic mat_t fill(input int v, input bit ident);
        mat_t m;
        for (int h = 0; h < 4; h++)
            for (int w = 0; w < 4; w++)
                m[h][w] = ident ? ((h == w) ? 8'sd1 : 8'sd0) : 8'(v);
        return m;
    endfunction

    // Beat j lands in row 3-j, so rows are sent bottom-first.
    task automatic load_w(input mat_t m);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            bus.w_valid = 1'b1;
            for (int w = 0; w < 4; w++) bus.wght[w] = m[3-j][w];
        end
        @(negedge clk);
        bus.w_valid = 1'b0;
    endtask

    task automatic set_ifm(input vec_t v);
        for (int h = 0; h < 4; h++) bus.ifm[h] = 8'(v[h]);
    endtask

    // Pulse start; lat counts cycles until ofm_valid is seen (1 = cycle after start).
    task automatic run(input logic md, input logic [7:0] n, input bit disturb,
                       input bit w_with_start, output int lat);
        @(negedge clk);
        bus.mode    = md;
        bus.mac_cyc = n;
        bus.start   = 1'b1;
        bus.w_valid = w_with_start;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.w_valid = 1'b0;
        lat = 1;
        while (!bus.ofm_valid && lat < 400) begin
            if (disturb && lat == 3) begin
                bus.start   = 1'b1;
                bus.w_valid = 1'b1;
                for (int w = 0; w < 4; w++) bus.wght[w] = 8'h55;
                for (int h = 0; h < 4; h++) bus.ifm[h] = 8'd5;
            end else begin
                bus.start   = 1'b0;
                bus.w_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.start   = 1'b0;
        bus.w_valid = 1'b0;
    endtask

    task automatic check_ofm(input string tag, input vec_t e);
        logic signed [23:0] v;
        for (int w = 0; w < 4; w++) begin
            v = bus.ofm[w];
            check($sformatf("%s_ofm%0d", tag, w), v, e[w]);
        end
    endtask

    // Called in the ofm_valid cycle: checks latency, results, and the busy fall one cycle later.
    task automatic finish_run(input string tag, input int lat, input int exp_lat, input vec_t e);
        check({tag, "_lat"}, lat, exp_lat);
        check_ofm(tag, e);
        check({tag, "_busy_done"}, bus.busy, 1);
        @(negedge clk);
        check({tag, "_busy_after"}, bus.busy, 0);
        check({tag, "_valid_pulse"}, bus.ofm_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   seen;
        int   err;
        logic signed [23:0] v;

        bus.w_valid = 1'b0;
        bus.wght    = '0;
        bus.start   = 1'b0;
        bus.mode    = 1'b0;
        bus.mac_cyc = '0;
        bus.ifm     = '0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.ofm_valid, 0);
        check_ofm("rst", '{0, 0, 0, 0});

        // Identity weights, full temporal window.
        load_w(fill(0, 1'b1));
        set_ifm('{3, -5, 0, 127});
        check("t1_idle_busy", bus.busy, 0);
        run(1'b0, 8'd0, 1'b0, 1'b0, lat);
        finish_run("t1", lat, 138, '{3, -5, 0, 127});

        // Most negative weights with saturated inputs: 4 * 127 * -128.
        load_w(fill(-128, 1'b0));
        set_ifm('{127, 127, 127, 127});
        run(1'b0, 8'd128, 1'b0, 1'b0, lat);
        finish_run("t2", lat, 138, '{-65024, -65024, -65024, -65024});

        // Early termination: window 4 clips each row to min(10,4).
        load_w(fill(1, 1'b0));
        set_ifm('{10, 10, 10, 10});
        run(1'b0, 8'd4, 1'b0, 1'b0, lat);
        finish_run("t3", lat, 14, '{16, 16, 16, 16});

        // Rate coding over one full LFSR period: m=127 is all ones, m=0 all zeros.
        load_w(fill(2, 1'b0));
        set_ifm('{127, 0, 127, 0});
        run(1'b1, 8'd127, 1'b0, 1'b0, lat);
        finish_run("t4", lat, 137, '{508, 508, 508, 508});

        // Rate coding with mixed inputs: golden 2*(45-100+77-3)=38, tolerance 8% of 4*127*2.
        set_ifm('{45, -100, 77, -3});
        run(1'b1, 8'd127, 1'b0, 1'b0, lat);
        check("t4r_lat", lat, 137);
        for (int w = 0; w < 4; w++) begin
            v = bus.ofm[w];
            err = int'(v) - 38;
            if (err < 0) err = -err;
            check($sformatf("t4r_err%0d_le81", w), (err <= 81) ? 1 : 0, 1);
        end

        // start/w_valid/ifm disturbed during MAC must not affect the run.
        load_w(fill(0, 1'b1));
        set_ifm('{3, -5, 0, 127});
        run(1'b0, 8'd0, 1'b1, 1'b0, lat);
        finish_run("t5", lat, 138, '{3, -5, 0, 127});

        // start together with w_valid: weights stay identity.
        for (int w = 0; w < 4; w++) bus.wght[w] = 8'd7;
        set_ifm('{1, 1, 1, 1});
        run(1'b0, 8'd0, 1'b0, 1'b1, lat);
        finish_run("t5b", lat, 138, '{1, 1, 1, 1});

        // Mid-run reset aborts: busy and ofm clear the next cycle, no ofm_valid.
        set_ifm('{3, -5, 0, 127});
        @(negedge clk);
        bus.mac_cyc = 8'd0;
        bus.mode    = 1'b0;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_busy", bus.busy, 0);
        check_ofm("t6", '{0, 0, 0, 0});
        seen = 0;
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            if (bus.ofm_valid) seen++;
        end
        check("t6_no_valid", seen, 0);

        load_w(fill(0, 1'b1));
        run(1'b0, 8'd0, 1'b0, 1'b0, lat);
        finish_run("t6r", lat, 138, '{3, -5, 0, 127});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
